minterm_sweeper: RTL and testbench

- Sequential exhaustive tester for N-input single-output combinational gate modules.
- Drives every minterm 0..2^N-1 onto a shared stimulus bus and compares the outputs of two implementations of the same function (gate-level vs expression-level).
- Reports mismatch count, first failing minterm and a per-minterm error mask.
- Sits in the bench beside the two DUT instances and replaces the hand-written stimulus sequences.

---
 rtl/minterm_sweeper.sv | 162 ++++++++++++++++
 tb/tb_minterm_sweeper.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/minterm_sweeper.sv
`timescale 1ns/1ps
// ============================================================================
// minterm_sweeper
// ----------------------------------------------------------------------------
// Exhaustive sequential tester for N-input, single-output combinational
// functions. It drives every minterm 0..2^N-1 onto a shared stimulus bus x.
// It compares two implementations of the same function (sa vs sb) and
// collects the mismatch count, the lowest failing minterm and a per-minterm
// error mask.
//
// Parameters:
//   N     number of function inputs (1..8)
//   HOLD  clock cycles each minterm is applied before sampling (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      begin a sweep (honoured only in IDLE or DONE)
//   loop       when high, DONE automatically restarts a new sweep
//   sa, sb     outputs of implementation A / B, combinational from x
//   x          registered stimulus (minterm index, MSB = first input)
//   busy       high while sweeping
//   done       high once a sweep has completed
//   pass       valid in DONE; high iff no minterm mismatched
//   err_count  number of mismatching minterms in the last/current sweep
//   first_bad  lowest-numbered mismatching minterm
//   bad_valid  first_bad holds a valid value
//   err_mask   bit m set iff minterm m mismatched
// ============================================================================
module minterm_sweeper #(
    parameter int N    = 2,
    parameter int HOLD = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              loop,
    input  logic              sa,
    input  logic              sb,
    output logic [N-1:0]      x,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N:0]        err_count,
    output logic [N-1:0]      first_bad,
    output logic              bad_valid,
    output logic [2**N-1:0]   err_mask
);

    // Hold counter must be at least one bit wide even when HOLD == 1.
    localparam int               HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD - 1);
    localparam logic [N-1:0]     X_LAST    = '1;
    localparam logic [N:0]       CNT_ONE   = (N+1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [HW-1:0]   hold_cnt;
    logic            sample;
    logic            last;
    logic            restart;
    logic            mismatch;

    // ------------------------------------------------------------------
    // Decode of the current cycle
    // ------------------------------------------------------------------
    always_comb begin
        // sa/sb are only looked at on the final cycle of each minterm, so
        // settling glitches in the earlier HOLD-1 cycles never count.
        sample   = (state == RUN) && (hold_cnt == HOLD_LAST);
        last     = (x == X_LAST);
        mismatch = sa ^ sb;
        // start and loop together in DONE still give a single restart.
        restart  = ((state == IDLE) && start) ||
                   ((state == DONE) && (start || loop));
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start)           state_next = RUN;
            RUN:  if (sample && last)  state_next = DONE;
            DONE: if (start || loop)   state_next = RUN;
            default:                   state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus, hold counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x         <= '0;
            hold_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            first_bad <= '0;
            bad_valid <= 1'b0;
            err_mask  <= '0;
        end else begin
            // busy/done follow the state being entered so that they are
            // registered yet line up exactly with RUN / DONE.
            busy <= (state_next == RUN);
            done <= (state_next == DONE);

            if (restart) begin
                x         <= '0;
                hold_cnt  <= '0;
                err_count <= '0;
                err_mask  <= '0;
                first_bad <= '0;
                bad_valid <= 1'b0;
            end else if (state == RUN) begin
                if (sample) begin
                    hold_cnt <= '0;
                    if (mismatch) begin
                        // At most 2^N increments per sweep; N+1 bits hold it.
                        err_count   <= err_count + CNT_ONE;
                        err_mask[x] <= 1'b1;
                        // Minterms are visited in ascending order, so the
                        // first one recorded is also the lowest-numbered.
                        if (!bad_valid) begin
                            first_bad <= x;
                            bad_valid <= 1'b1;
                        end
                    end
                    // x parks on the last minterm; only a restart wraps it.
                    if (!last) begin
                        x <= x + 1'b1;
                    end
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

    // pass is the only decoded output: meaningful only while in DONE.
    assign pass = (state == DONE) && (err_count == '0);

endmodule

// File: tb/tb_minterm_sweeper.sv
`timescale 1ns/1ps
// Directed bench for minterm_sweeper: three instances with different N/HOLD
// and bench-side reference functions wired to sa/sb.
module tb_minterm_sweeper;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance 0: N=2, HOLD=1 ----------------
    logic       start0 = 1'b0, loop0 = 1'b0, mode0 = 1'b0;
    logic       sa0, sb0, busy0, done0, pass0, bv0;
    logic [1:0] x0, fb0;
    logic [2:0] ec0;
    logic [3:0] em0;
    // mode0=0: sa = a'.b, sb = a'+b'  (mismatch at minterms 0 and 2)
    // mode0=1: sb = sa except minterm 1 inverted
    assign sa0 = ~x0[1] & x0[0];
    assign sb0 = mode0 ? (sa0 ^ (x0 == 2'd1)) : (~x0[1] | ~x0[0]);

    minterm_sweeper #(.N(2), .HOLD(1)) u0 (
        .clk(clk), .reset(reset), .start(start0), .loop(loop0),
        .sa(sa0), .sb(sb0), .x(x0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(ec0), .first_bad(fb0),
        .bad_valid(bv0), .err_mask(em0)
    );

    // ---------------- instance 1: N=2, HOLD=3 ----------------
    logic       start1 = 1'b0;
    logic       sa1, sb1, busy1, done1, pass1, bv1;
    logic [1:0] x1, fb1;
    logic [2:0] ec1;
    logic [3:0] em1;
    assign sa1 = ~x1[1] & x1[0];
    assign sb1 = ~x1[1] & x1[0];

    minterm_sweeper #(.N(2), .HOLD(3)) u1 (
        .clk(clk), .reset(reset), .start(start1), .loop(1'b0),
        .sa(sa1), .sb(sb1), .x(x1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(ec1), .first_bad(fb1),
        .bad_valid(bv1), .err_mask(em1)
    );

    // ---------------- instance 2: N=3, HOLD=1 ----------------
    logic       start2 = 1'b0;
    logic       sa2, sb2, busy2, done2, pass2, bv2;
    logic [2:0] x2, fb2;
    logic [3:0] ec2;
    logic [7:0] em2;
    assign sa2 = x2[0] ^ x2[2];
    assign sb2 = sa2 ^ (x2 == 3'd7);

    minterm_sweeper #(.N(3), .HOLD(1)) u2 (
        .clk(clk), .reset(reset), .start(start2), .loop(1'b0),
        .sa(sa2), .sb(sb2), .x(x2), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(ec2), .first_bad(fb2),
        .bad_valid(bv2), .err_mask(em2)
    );

    // ------------------------------------------------------------------
    task automatic test_reset();
        #2;
        checks++; if (x0 !== 2'd0)    begin errors++; $display("FAIL rst_x x=%0d expected 0", x0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy busy=%0b expected 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rst_done done=%0b expected 0", done0); end
        checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL rst_pass pass=%0b expected 0", pass0); end
        checks++; if (ec0 !== 3'd0)   begin errors++; $display("FAIL rst_ec err_count=%0d expected 0", ec0); end
        checks++; if (em0 !== 4'd0)   begin errors++; $display("FAIL rst_em err_mask=%b expected 0000", em0); end
        checks++; if (bv0 !== 1'b0)   begin errors++; $display("FAIL rst_bv bad_valid=%0b expected 0", bv0); end
        checks++; if (fb0 !== 2'd0)   begin errors++; $display("FAIL rst_fb first_bad=%0d expected 0", fb0); end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL idle_hold busy=%0b done=%0b expected 0 0", busy0, done0); end
    endtask

    // N=2 HOLD=1, sa=a'.b vs sb=a'+b'
    task automatic test_mismatch();
        mode0 = 1'b0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (x0 !== 2'(i))   begin errors++; $display("FAIL mm_x%0d x=%0d expected %0d", i, x0, i); end
            checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL mm_busy%0d busy=%0b expected 1", i, busy0); end
            checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL mm_done%0d done=%0b expected 0", i, done0); end
            @(negedge clk);
        end
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL mm_done done=%0b expected 1", done0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL mm_busy busy=%0b expected 0", busy0); end
        checks++; if (ec0 !== 3'd2)   begin errors++; $display("FAIL mm_ec err_count=%0d expected 2", ec0); end
        checks++; if (em0 !== 4'b0101) begin errors++; $display("FAIL mm_em err_mask=%b expected 0101", em0); end
        checks++; if (fb0 !== 2'd0)   begin errors++; $display("FAIL mm_fb first_bad=%0d expected 0", fb0); end
        checks++; if (bv0 !== 1'b1)   begin errors++; $display("FAIL mm_bv bad_valid=%0b expected 1", bv0); end
        checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL mm_pass pass=%0b expected 0", pass0); end
        checks++; if (x0 !== 2'd3)    begin errors++; $display("FAIL mm_xpark x=%0d expected 3", x0); end
    endtask

    // N=2 HOLD=3, identical functions
    task automatic test_hold();
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checks++; if (x1 !== 2'(i / 3)) begin errors++; $display("FAIL hold_x%0d x=%0d expected %0d", i, x1, i / 3); end
            checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL hold_st%0d busy=%0b done=%0b expected 1 0", i, busy1, done1); end
            @(negedge clk);
        end
        checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL hold_done done=%0b expected 1", done1); end
        checks++; if (ec1 !== 3'd0)   begin errors++; $display("FAIL hold_ec err_count=%0d expected 0", ec1); end
        checks++; if (em1 !== 4'd0)   begin errors++; $display("FAIL hold_em err_mask=%b expected 0000", em1); end
        checks++; if (bv1 !== 1'b0)   begin errors++; $display("FAIL hold_bv bad_valid=%0b expected 0", bv1); end
        checks++; if (pass1 !== 1'b1) begin errors++; $display("FAIL hold_pass pass=%0b expected 1", pass1); end
    endtask

    // N=3 HOLD=1, only minterm 7 differs
    task automatic test_n3();
        int cnt;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        cnt = 0;
        while (done2 !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        checks++; if (cnt !== 8)      begin errors++; $display("FAIL n3_len cycles=%0d expected 8", cnt); end
        checks++; if (ec2 !== 4'd1)   begin errors++; $display("FAIL n3_ec err_count=%0d expected 1", ec2); end
        checks++; if (fb2 !== 3'd7)   begin errors++; $display("FAIL n3_fb first_bad=%0d expected 7", fb2); end
        checks++; if (em2 !== 8'h80)  begin errors++; $display("FAIL n3_em err_mask=%h expected 80", em2); end
        checks++; if (bv2 !== 1'b1)   begin errors++; $display("FAIL n3_bv bad_valid=%0b expected 1", bv2); end
        checks++; if (pass2 !== 1'b0) begin errors++; $display("FAIL n3_pass pass=%0b expected 0", pass2); end
    endtask

    // start pulses while sweeping must not disturb the sweep
    task automatic test_start_in_run();
        mode0 = 1'b1;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start0 = (i == 1 || i == 2);
            checks++; if (x0 !== 2'(i) || busy0 !== 1'b1) begin errors++; $display("FAIL sir_x%0d x=%0d busy=%0b expected %0d 1", i, x0, busy0, i); end
            @(negedge clk);
        end
        start0 = 1'b0;
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL sir_done done=%0b expected 1", done0); end
        checks++; if (ec0 !== 3'd1)   begin errors++; $display("FAIL sir_ec err_count=%0d expected 1", ec0); end
        checks++; if (em0 !== 4'b0010) begin errors++; $display("FAIL sir_em err_mask=%b expected 0010", em0); end
        checks++; if (fb0 !== 2'd1)   begin errors++; $display("FAIL sir_fb first_bad=%0d expected 1", fb0); end
    endtask

    // Shared body for the auto-restart scenarios: 4 RUN cycles + 1 DONE cycle
    // repeating, with the single mismatch at minterm 1 counted on cycle 2.
    task automatic run_restart_pattern(input string tag);
        for (int i = 0; i < 15; i++) begin
            int ph;
            ph = i % 5;
            checks++; if (done0 !== (ph == 4)) begin errors++; $display("FAIL %s_done%0d done=%0b expected %0b", tag, i, done0, ph == 4); end
            checks++; if (ec0 !== ((ph >= 2) ? 3'd1 : 3'd0)) begin errors++; $display("FAIL %s_ec%0d err_count=%0d expected %0d", tag, i, ec0, (ph >= 2) ? 1 : 0); end
            checks++; if (x0 !== ((ph == 4) ? 2'd3 : 2'(ph))) begin errors++; $display("FAIL %s_x%0d x=%0d expected %0d", tag, i, x0, (ph == 4) ? 3 : ph); end
            @(negedge clk);
        end
    endtask

    task automatic settle_in_done(input string tag);
        int cnt;
        cnt = 0;
        while (done0 !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL %s_end done=%0b expected 1", tag, done0); end
        repeat (2) @(negedge clk);
        checks++; if (done0 !== 1'b1 || ec0 !== 3'd1) begin errors++; $display("FAIL %s_stay done=%0b err_count=%0d expected 1 1", tag, done0, ec0); end
    endtask

    task automatic test_loop();
        mode0 = 1'b1;
        @(negedge clk); start0 = 1'b1; loop0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        run_restart_pattern("loop");
        loop0 = 1'b0;
        settle_in_done("loop");
    endtask

    task automatic test_start_held();
        mode0 = 1'b1;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk);
        run_restart_pattern("held");
        start0 = 1'b0;
        settle_in_done("held");
    endtask

    task automatic test_reset_mid_run();
        mode0 = 1'b0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (x0 !== 2'd2 || ec0 !== 3'd1) begin errors++; $display("FAIL rmr_pre x=%0d err_count=%0d expected 2 1", x0, ec0); end
        #2 reset = 1'b1;
        #1;
        checks++; if (x0 !== 2'd0)    begin errors++; $display("FAIL rmr_x x=%0d expected 0", x0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rmr_busy busy=%0b expected 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rmr_done done=%0b expected 0", done0); end
        checks++; if (ec0 !== 3'd0)   begin errors++; $display("FAIL rmr_ec err_count=%0d expected 0", ec0); end
        checks++; if (em0 !== 4'd0)   begin errors++; $display("FAIL rmr_em err_mask=%b expected 0000", em0); end
        checks++; if (bv0 !== 1'b0)   begin errors++; $display("FAIL rmr_bv bad_valid=%0b expected 0", bv0); end
        @(negedge clk); reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy0 !== 1'b0 || done0 !== 1'b0 || x0 !== 2'd0) begin errors++; $display("FAIL rmr_idle busy=%0b done=%0b x=%0d expected 0 0 0", busy0, done0, x0); end
    endtask

    initial begin
        test_reset();
        test_mismatch();
        test_hold();
        test_n3();
        test_start_in_run();
        test_loop();
        test_start_held();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
